// File: rtl/array_collect_pkg.sv
// Shared types and helpers for the array_collect serial-to-parallel packer.
// Optional idle timeout is enabled by defining ARRAY_COLLECT_TIMEOUT_EN.
package array_collect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int FIDX_W = 16;

    // Fill-count width: clog2(LEN), never below one bit.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/array_collect_slot_wr.sv
// Write decoder: returns the capture buffer with din placed into slot `slot`.
// Slot k occupies bits [(k+1)*W-1 : k*W]; all other slots pass through unchanged.
module array_collect_slot_wr #(
    parameter int W   = 10,
    parameter int LEN = 16,
    parameter int CW  = 4
) (
    input  logic [LEN*W-1:0] buf_in,
    input  logic [CW-1:0]    slot,
    input  logic [W-1:0]     din,
    output logic [LEN*W-1:0] buf_out
);

    always_comb begin
        buf_out = buf_in;
        for (int k = 0; k < LEN; k++) begin
            if (slot == CW'(k)) begin
                buf_out[k*W +: W] = din;
            end
        end
    end

endmodule

// File: rtl/array_collect.sv
// Collects a serial stream of signed samples into a packed LEN*W frame with a one-cycle strobe.
// Defining ARRAY_COLLECT_TIMEOUT_EN adds an idle timeout that discards stalled partial frames.
module array_collect
    import array_collect_pkg::*;
#(
    parameter int W           = 10,
    parameter int LEN         = 16,
    parameter int SYNC_ON_SOF = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              din_sof,
    input  logic [W-1:0]      din,
    output logic [LEN*W-1:0]  array_out,
    output logic              array_valid,
    output logic [FIDX_W-1:0] frame_idx,
    output logic              frame_err,
    output state_t            fsm_state
);

    localparam int CW = cnt_width(LEN);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   slot;
    logic [LEN*W-1:0] cap_buf;
    logic [LEN*W-1:0] buf_next;
    logic            first_done;
    logic            accept;
    logic            restart;
    logic            complete;
    logic            timeout;

    // A sof arriving while a frame is partially filled restarts the frame at slot 0.
    always_comb begin
        accept   = din_valid && ((state == FILL) || din_sof || (SYNC_ON_SOF == 0));
        restart  = din_valid && (state == FILL) && din_sof && (cnt != '0);
        slot     = ((state == IDLE) || restart) ? '0 : cnt;
        complete = accept && !restart && (slot == LAST);
    end

    array_collect_slot_wr #(
        .W   (W),
        .LEN (LEN),
        .CW  (CW)
    ) u_slot_wr (
        .buf_in  (cap_buf),
        .slot    (slot),
        .din     (din),
        .buf_out (buf_next)
    );

`ifdef ARRAY_COLLECT_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;

    assign timeout = !din_valid && (state == FILL) && (cnt != '0) && (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || din_valid) begin
            idle_cnt <= '0;
        end else if ((state == FILL) && (cnt != '0)) begin
            idle_cnt <= timeout ? '0 : idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Capture buffer needs no reset: every slot is rewritten before a frame completes.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_buf <= buf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            array_out   <= '0;
            array_valid <= 1'b0;
            frame_idx   <= '0;
            frame_err   <= 1'b0;
            first_done  <= 1'b0;
        end else begin
            array_valid <= complete;
            frame_err   <= restart || timeout;
            if (accept) begin
                state <= FILL;
                cnt   <= complete ? '0 : slot + 1'b1;
            end else if (timeout) begin
                state <= IDLE;
                cnt   <= '0;
            end
            if (complete) begin
                array_out  <= buf_next;
                first_done <= 1'b1;
                if (first_done) begin
                    frame_idx <= frame_idx + 1'b1;
                end
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_array_collect.sv
// Bench for array_collect: directed vector table, LEN=1 free-running instance, randomized run vs queue model.
// Timeout rows and model behaviour follow ARRAY_COLLECT_TIMEOUT_EN.
module tb_array_collect;
  import array_collect_pkg::*;

  localparam int W = 8;
  localparam int LEN = 4;
  localparam int SYNC = 1;
  localparam int TMO = 4;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic dv = 1'b0, ds = 1'b0;
  logic [W-1:0] dd = '0;
  logic [LEN*W-1:0] ao;
  logic av, fe;
  logic [15:0] fi;
  state_t st;

  logic d1v = 1'b0;
  logic d1s = 1'b0;
  logic [W-1:0] d1d = '0;
  logic [W-1:0] ao1;
  logic av1, fe1;
  logic [15:0] fi1;
  state_t st1;

  array_collect #(.W(W), .LEN(LEN), .SYNC_ON_SOF(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .din_valid(dv), .din_sof(ds), .din(dd),
    .array_out(ao), .array_valid(av), .frame_idx(fi), .frame_err(fe), .fsm_state(st)
  );

  array_collect #(.W(W), .LEN(1), .SYNC_ON_SOF(0), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst), .din_valid(d1v), .din_sof(d1s), .din(d1d),
    .array_out(ao1), .array_valid(av1), .frame_idx(fi1), .frame_err(fe1), .fsm_state(st1)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // driver: inputs change at negedge, outputs of that edge are visible at the next negedge
  task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    rst = r; dv = v; ds = s; dd = d;
    @(negedge clk);
  endtask

  typedef struct {
    logic r, v, s;
    logic [W-1:0] d;
    logic ev, ee;
    logic [31:0] eo;
    logic [15:0] ei;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic v, input logic s, input logic [W-1:0] d,
                              input logic ev, input logic ee, input logic [31:0] eo, input logic [15:0] ei);
    vec_t e;
    e.r = r; e.v = v; e.s = s; e.d = d; e.ev = ev; e.ee = ee; e.eo = eo; e.ei = ei;
    tbl.push_back(e);
  endfunction

  // scoreboard / reference model: a frame is simply the list of accepted samples
  logic [W-1:0] exp_q[$];
  bit active;
  int frames, idle;
  logic m_valid, m_err;
  logic [31:0] m_out;
  logic [15:0] m_idx;

  task automatic model(input logic r, input logic v, input logic s, input logic [W-1:0] d);
    m_valid = 1'b0;
    m_err = 1'b0;
    if (r) begin
      exp_q.delete(); active = 0; frames = 0; idle = 0; m_out = '0; m_idx = '0;
    end else if (v) begin
      idle = 0;
      if (!active) begin
        if (s || SYNC == 0) begin exp_q.delete(); exp_q.push_back(d); active = 1; end
      end else if (s && exp_q.size() != 0) begin
        m_err = 1'b1; exp_q.delete(); exp_q.push_back(d);
      end else begin
        exp_q.push_back(d);
      end
      if (exp_q.size() == LEN) begin
        m_valid = 1'b1;
        m_out = '0;
        for (int k = 0; k < LEN; k++) m_out[k*W +: W] = exp_q[k];
        m_idx = 16'(frames);
        frames++;
        exp_q.delete();
      end
    end else begin
`ifdef ARRAY_COLLECT_TIMEOUT_EN
      if (exp_q.size() != 0) begin
        idle++;
        if (idle == TMO) begin
          m_err = 1'b1; exp_q.delete(); active = 0; idle = 0;
        end
      end
`endif
    end
  endtask

  initial begin
    // reset
    add(1,0,0,8'h00, 0,0,32'h0,0);
    add(1,0,0,8'h00, 0,0,32'h0,0);
    // back-to-back frames
    add(0,1,1,8'h01, 0,0,32'h0,0);
    add(0,1,0,8'h02, 0,0,32'h0,0);
    add(0,1,0,8'h03, 0,0,32'h0,0);
    add(0,1,0,8'h04, 1,0,32'h04030201,0);
    add(0,1,1,8'h05, 0,0,32'h04030201,0);
    add(0,1,0,8'h06, 0,0,32'h04030201,0);
    add(0,1,0,8'h07, 0,0,32'h04030201,0);
    add(0,1,0,8'h08, 1,0,32'h08070605,1);
    add(0,0,0,8'h00, 0,0,32'h08070605,1);
    add(1,0,0,8'h00, 0,0,32'h0,0);
    // pre-sof samples dropped, gaps held
    add(0,1,0,8'h09, 0,0,32'h0,0);
    add(0,1,0,8'h09, 0,0,32'h0,0);
    add(0,1,1,8'hFF, 0,0,32'h0,0);
    add(0,0,0,8'h00, 0,0,32'h0,0);
    add(0,0,0,8'h00, 0,0,32'h0,0);
    add(0,1,0,8'h80, 0,0,32'h0,0);
    add(0,1,0,8'h7F, 0,0,32'h0,0);
    add(0,1,0,8'h01, 1,0,32'h017F80FF,0);
    // mid-frame sof
    add(0,1,1,8'h01, 0,0,32'h017F80FF,0);
    add(0,1,0,8'h02, 0,0,32'h017F80FF,0);
    add(0,1,1,8'h0A, 0,1,32'h017F80FF,0);
    add(0,1,0,8'h0B, 0,0,32'h017F80FF,0);
    add(0,1,0,8'h0C, 0,0,32'h017F80FF,0);
    add(0,1,0,8'h0D, 1,0,32'h0D0C0B0A,1);
    // reset mid-frame
    add(0,1,1,8'h01, 0,0,32'h0D0C0B0A,1);
    add(0,1,0,8'h02, 0,0,32'h0D0C0B0A,1);
    add(1,0,0,8'h00, 0,0,32'h0,0);
    add(0,1,1,8'h01, 0,0,32'h0,0);
    add(0,1,0,8'h02, 0,0,32'h0,0);
    add(0,1,0,8'h03, 0,0,32'h0,0);
    add(0,1,0,8'h04, 1,0,32'h04030201,0);
    // sof on the completing sample restarts instead of completing
    add(0,1,1,8'h01, 0,0,32'h04030201,0);
    add(0,1,0,8'h02, 0,0,32'h04030201,0);
    add(0,1,0,8'h03, 0,0,32'h04030201,0);
    add(0,1,1,8'h04, 0,1,32'h04030201,0);
    add(0,1,0,8'h05, 0,0,32'h04030201,0);
    add(0,1,0,8'h06, 0,0,32'h04030201,0);
    add(0,1,0,8'h07, 1,0,32'h07060504,1);
    // stalled partial frame
    add(0,1,1,8'h01, 0,0,32'h07060504,1);
`ifdef ARRAY_COLLECT_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) add(0,0,0,8'h00, 0,0,32'h07060504,1);
    add(0,0,0,8'h00, 0,1,32'h07060504,1);
    add(0,0,0,8'h00, 0,0,32'h07060504,1);
    add(0,1,0,8'h02, 0,0,32'h07060504,1);
    add(0,1,1,8'h01, 0,0,32'h07060504,1);
`else
    for (int i = 0; i < 10; i++) add(0,0,0,8'h00, 0,0,32'h07060504,1);
`endif
    add(0,1,0,8'h02, 0,0,32'h07060504,1);
    add(0,1,0,8'h03, 0,0,32'h07060504,1);
    add(0,1,0,8'h04, 1,0,32'h04030201,2);
    add(0,0,0,8'h00, 0,0,32'h04030201,2);

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("row%0d array_valid", i), 32'(av), 32'(tbl[i].ev));
      check($sformatf("row%0d frame_err", i), 32'(fe), 32'(tbl[i].ee));
      check($sformatf("row%0d array_out", i), ao, tbl[i].eo);
      check($sformatf("row%0d frame_idx", i), 32'(fi), 32'(tbl[i].ei));
      if (tbl[i].r) check($sformatf("row%0d state", i), 32'(st), 32'(IDLE));
    end

    // LEN=1, no sof sync: every valid sample is a frame
    for (int i = 0; i < 3; i++) begin
      d1v = 1'b1; d1d = 8'(5 + i);
      @(negedge clk);
      check($sformatf("len1 valid%0d", i), 32'(av1), 32'd1);
      check($sformatf("len1 out%0d", i), 32'(ao1), 32'(5 + i));
      check($sformatf("len1 idx%0d", i), 32'(fi1), 32'(i));
      check($sformatf("len1 err%0d", i), 32'(fe1), 32'd0);
    end
    d1v = 1'b0;
    @(negedge clk);
    check("len1 gap valid", 32'(av1), 32'd0);
    check("len1 gap out", 32'(ao1), 32'd7);

    // randomized run against the model
    step(1, 0, 0, 8'h00);
    model(1, 0, 0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      logic r, v, s;
      logic [W-1:0] d;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 4) == 0);
      d = W'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        for (int g = 0; g < TMO + 1; g++) begin
          step(0, 0, 0, 8'h00);
          model(0, 0, 0, 8'h00);
          check("rnd gap frame_err", 32'(fe), 32'(m_err));
          check("rnd gap array_valid", 32'(av), 32'(m_valid));
        end
      end
      step(r, v, s, d);
      model(r, v, s, d);
      check("rnd array_valid", 32'(av), 32'(m_valid));
      check("rnd frame_err", 32'(fe), 32'(m_err));
      check("rnd array_out", ao, m_out);
      check("rnd frame_idx", 32'(fi), 32'(m_idx));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/array_collect.md
Name: array_collect

Overview:
- Upstream packer for the array-dump stage: collects a serial stream of signed samples into one packed LEN*W-bit array.
- Emits a one-cycle enable strobe when the array is complete.
- Output pair (array_out, array_valid) is wired directly to the dump stage's signal_out/enable.
- Synthesizable. Used in the sort datapath wherever a per-sample stream must be presented as a parallel vector.

Parameters:
- W, 10, sample width in bits (signed).
- LEN, 16, samples per frame; legal 1..1024.
- SYNC_ON_SOF, 1, 1: filling starts only on a sample flagged din_sof; 0: any valid sample starts a frame.
- TIMEOUT, 64, idle-cycle limit mid-frame; only used with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- din_valid  in  1  din is a valid sample this cycle
- din_sof  in  1  qualifies din as sample 0 of a frame; ignored when din_valid=0
- din  in  W  signed sample
- array_out  out  LEN*W  completed frame; sample k at bits [(k+1)*W-1 : k*W]
- array_valid  out  1  one-cycle strobe: array_out updated this cycle
- frame_idx  out  16  index of the frame currently on array_out, 0-based
- frame_err  out  1  one-cycle pulse: a partial frame was discarded

Behaviour:
- Reset (sync, rst=1 at an edge) forces:
  - array_out=0, array_valid=0, frame_idx=0, frame_err=0
  - fill count cnt=0, state IDLE
  - The capture buffer is not required to be cleared.
- Reset mid-frame discards the partial frame silently; no frame_err.
- cnt width is clog2(LEN), minimum 1.
- State IDLE:
  - On din_valid and (din_sof or SYNC_ON_SOF=0): write din to capture slot 0, cnt=1, go to FILL.
  - If LEN=1, this instead completes the frame (see completion rule below).
  - Valid samples without sof while SYNC_ON_SOF=1 are dropped; no error.
- State FILL, on din_valid:
  - din_sof with cnt!=0: the partial frame is discarded. frame_err=1 next cycle. din is written to slot 0, cnt=1, stay in FILL.
  - Otherwise: write din to slot cnt, cnt=cnt+1.
- Completion, when the sample written lands in slot LEN-1:
  - At that same edge, array_out is loaded with the full buffer including that sample.
  - array_valid=1 for exactly that following cycle; cnt=0.
  - frame_idx increments on every completion except the first after reset (first frame shows 0). It wraps 0xFFFF->0.
  - State stays FILL, so back-to-back frames with no gap are legal and sustain one sample per cycle.
- din_valid=0 cycles hold all state; gaps of any length are legal.
- Latency: last sample's edge -> array_valid high in the next cycle (1 cycle).
- array_out and frame_idx are held constant between strobes.
- din_sof on the sample at cnt=0 in FILL is normal and raises no error.
- din_sof on the completing sample (cnt=LEN-1, LEN>1) counts as mid-frame: error and restart, no completion.

Optional Feature:
- Macro: ARRAY_COLLECT_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive din_valid=0 cycles while in FILL with cnt!=0.
  - On reaching TIMEOUT: partial frame discarded, frame_err pulses 1 cycle, cnt=0, state IDLE.
  - The idle counter clears on any valid sample and on reset.
- Not defined: no idle counter; a partial frame waits indefinitely.

Decomposition:
- Shared package: state enum (IDLE, FILL), clog2 helper constant, frame_idx width constant (16).
- One natural sub-module: array_collect_slot_wr, a write-decoder placing a W-bit sample into slot cnt of the LEN*W buffer.
- Top holds the FSM, counters and output register.

Test Plan (W=8, LEN=4, SYNC_ON_SOF=1 unless noted):
- Back-to-back frames:
  - Stimulus: sof+1,2,3,4 on 4 consecutive valids, then sof+5,6,7,8 immediately.
  - Required: array_out=0x04030201 with frame_idx=0, then 0x08070605 with frame_idx=1. array_valid high exactly 1 cycle each, one cycle after samples 4 and 8.
- Gaps and pre-sof samples:
  - Stimulus: samples 9, 9 without sof; then sof+0xFF, 2-cycle gap, 0x80, 0x7F, 0x01.
  - Required: the two 9s are ignored, array_out=0x017F80FF, frame_err stays 0.
- Mid-frame sof:
  - Stimulus: sof+1, 2, then sof+0xA, 0xB, 0xC, 0xD.
  - Required: frame_err pulses once; the next array_valid gives array_out=0x0D0C0B0A.
- Reset mid-frame:
  - Stimulus: rst=1 for 1 cycle after 2 samples, then a full frame 1..4.
  - Required: all outputs 0 during and after reset; array_out=0x04030201, frame_idx=0, no frame_err.
- SYNC_ON_SOF=0, LEN=1:
  - Stimulus: valids 5, 6, 7.
  - Required: three strobes, array_out=5, 6, 7 with frame_idx=0, 1, 2.
- ARRAY_COLLECT_TIMEOUT_EN defined, TIMEOUT=4:
  - Stimulus: sof+1, then 4 idle cycles.
  - Required: frame_err pulse; a following sof frame 1..4 completes normally.
